return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Hardware LIFO of return addresses for the single-cycle I/O CPU.
- It responds to the wesp/push/pop strobes that the control unit drives on call (jal) and return (ret) opcodes.
- On a call it stores PC+1 supplied by the datapath. On a return it presents the top entry combinationally, so the PC mux can select it in the same cycle.
- Sits beside the PC register; its output feeds the next-PC multiplexer.

Parameters:
- AW, 10, width of a program address (PC width).
- DEPTH, 16, number of stack entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived localparam, not overridable).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- wesp  input  1  stack write enable from control unit; push/pop are ignored unless 1.
- push  input  1  store ret_addr_in as a new top entry.
- pop  input  1  discard the top entry.
- ret_addr_in  input  AW  address to push (PC+1 from datapath).
- top_out  output  AW  current top entry (combinational); 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset==0 at a clk edge) has priority over every other input:
  - sp/count ← 0, overflow ← 0, underflow ← 0.
  - Storage array is not cleared.
  - Immediately after reset: top_out=0, empty=1, full=0, count=0.
  - Reset asserted in the same cycle as push/pop: the operation is dropped.
- Storage: DEPTH×AW array with synchronous write and asynchronous read. top_out = mem[sp-1] when count>0, else 0.
- Operation select, evaluated at the clk edge when reset==1:
  - wesp=0: no change, regardless of push/pop (control unit may leave push/pop stale).
  - wesp=1, push=1, pop=0, not full: mem[sp] ← ret_addr_in; sp ← sp+1.
  - wesp=1, push=1, pop=0, full: no write, sp unchanged, overflow ← 1.
  - wesp=1, pop=1, push=0, not empty: sp ← sp-1. Entry is not erased.
  - wesp=1, pop=1, push=0, empty: sp unchanged, underflow ← 1.
  - wesp=1, push=1, pop=1, not empty: replace top; mem[sp-1] ← ret_addr_in; sp unchanged.
  - wesp=1, push=1, pop=1, empty: behaves as a plain push.
  - wesp=1, push=0, pop=0: no change.
- Latency:
  - A push is visible on top_out the cycle after the edge.
  - A pop's data is consumed from top_out in the cycle the pop is asserted (single-cycle ret).
  - The new top appears after the edge.
- Pointer arithmetic:
  - sp is CW bits wide; count equals sp.
  - Index into the array with sp[CW-2:0] and (sp-1)[CW-2:0].
  - No wrap-around: sp is bounded 0..DEPTH by the full/empty guards.
- Sticky flags stay set until reset. They never block subsequent legal operations.
- Outputs empty, full and count are derived combinationally from sp; no extra registers.

Decomposition:
- Shared package cpu_pkg:
  - PC_W (=10) and RSTACK_DEPTH (=16) constants, used as defaults for AW/DEPTH.
  - 2-bit enum stack_op_t {SOP_NONE, SOP_PUSH, SOP_POP, SOP_REPL}, decoded from {wesp,push,pop}.
- One natural sub-module: stack_ram (DEPTH×AW, one sync write port, one async read port). Pointer/flag logic stays in return_stack.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release → count=0, empty=1, full=0, top_out=0, overflow=underflow=0.
- Push/pop order: push 0x005, 0x00A, 0x3FF with wesp=1 → count=3, top_out=0x3FF. Then pop ×3 → top_out sequence 0x3FF, 0x00A, 0x005 in each pop cycle; empty=1 afterwards.
- wesp gating: push=1 with ret_addr_in=0x123 and wesp=0 for 4 cycles → count stays 0, top_out=0.
- Full/overflow: push 16 values 0x010..0x01F → full=1. Then a 17th push of 0x2AA → overflow=1, count=16, top_out=0x01F. A following pop → top_out=0x01E, overflow still 1.
- Underflow and replace:
  - Pop on empty → underflow=1, count=0.
  - Push 0x040, then push=pop=1 with 0x041 → count=1, top_out=0x041.
- Reset mid-operation: after 3 pushes, assert reset=0 together with push of 0x077 → count=0, top_out=0, flags cleared. Next push of 0x001 → top_out=0x001.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the return-stack operation encoding.
package cpu_pkg;

  localparam int unsigned PC_W         = 10;
  localparam int unsigned RSTACK_DEPTH = 16;

  typedef enum logic [1:0] {
    SOP_NONE = 2'd0,
    SOP_PUSH = 2'd1,
    SOP_POP  = 2'd2,
    SOP_REPL = 2'd3
  } stack_op_t;

  // Collapses the control-unit strobes into one stack operation.
  function automatic stack_op_t decode_op(input logic wesp, input logic push, input logic pop);
    if (!wesp) return SOP_NONE;
    unique case ({push, pop})
      2'b10:   return SOP_PUSH;
      2'b01:   return SOP_POP;
      2'b11:   return SOP_REPL;
      default: return SOP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/return_stack_ram.sv
// Return-stack storage: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses; top entry is presented combinationally for single-cycle ret.
module return_stack
  import cpu_pkg::*;
#(
  parameter int unsigned AW    = PC_W,
  parameter int unsigned DEPTH = RSTACK_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wesp,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] ret_addr_in,
  output logic [AW-1:0] top_out,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned IW = CW - 1;

  logic [CW-1:0] sp;
  logic [CW-1:0] sp_m1;
  logic [CW-1:0] sp_next;
  logic [IW-1:0] waddr;
  logic [AW-1:0] rd_data;
  logic          we;
  logic          ovf_set;
  logic          unf_set;
  stack_op_t     op;

  assign op    = decode_op(wesp, push, pop);
  assign sp_m1 = sp - CW'(1);
  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == CW'(DEPTH));

  always_comb begin
    we      = 1'b0;
    waddr   = sp[IW-1:0];
    sp_next = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      SOP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          sp_next = sp + CW'(1);
        end
      end
      SOP_POP: begin
        if (empty) unf_set = 1'b1;
        else       sp_next = sp_m1;
      end
      SOP_REPL: begin
        // Replace on an empty stack degenerates to a plain push.
        we = 1'b1;
        if (empty) sp_next = sp + CW'(1);
        else       waddr   = sp_m1[IW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp_next;
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  // Write is gated by reset so an operation coinciding with reset is dropped entirely.
  stack_ram #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we && reset),
    .waddr (waddr),
    .wdata (ret_addr_in),
    .raddr (sp_m1[IW-1:0]),
    .rdata (rd_data)
  );

  assign top_out = empty ? '0 : rd_data;

endmodule

// File: tb/tb_return_stack.sv
// Directed, table-driven check of the return stack plus hand-written full/overflow and reset sequences.
module tb_return_stack;

  logic       clk = 1'b0;
  logic       reset, wesp, push, pop;
  logic [9:0] ret_addr_in;
  logic [9:0] top_out;
  logic [4:0] count;
  logic       empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  return_stack #(.AW(10), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .wesp        (wesp),
    .push        (push),
    .pop         (pop),
    .ret_addr_in (ret_addr_in),
    .top_out     (top_out),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct packed {
    logic       rst;
    logic       we;
    logic       pu;
    logic       po;
    logic [9:0] addr;
    logic       chk_pre;
    logic [9:0] pre_top;
    logic [4:0] cnt;
    logic [9:0] top;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, we, pu, po, input logic [9:0] addr,
                              input logic chk_pre, input logic [9:0] pre_top,
                              input logic [4:0] cnt, input logic [9:0] top,
                              input logic emp, ful, ovf, unf);
    vec_t v;
    v = '{rst, we, pu, po, addr, chk_pre, pre_top, cnt, top, emp, ful, ovf, unf};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, we, pu, po, input logic [9:0] a);
    @(negedge clk);
    reset = r; wesp = we; push = pu; pop = po; ret_addr_in = a;
    #1;
  endtask

  task automatic post(input string tag, input logic [4:0] c, input logic [9:0] t,
                      input logic e, f, o, u);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_top"},   32'(top_out), 32'(t));
    chk({tag, "_empty"}, 32'(empty), 32'(e));
    chk({tag, "_full"},  32'(full), 32'(f));
    chk({tag, "_ovf"},   32'(overflow), 32'(o));
    chk({tag, "_unf"},   32'(underflow), 32'(u));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; wesp = 1'b0; push = 1'b0; pop = 1'b0; ret_addr_in = '0;

    //              rst we pu po addr    pre pre_top cnt top     emp ful ovf unf
    vecs[0]  = mk(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 10'h000, 1, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 10'h005, 0, 10'h000, 1, 10'h005, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 1, 0, 10'h00A, 0, 10'h000, 2, 10'h00A, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 0, 10'h3FF, 0, 10'h000, 3, 10'h3FF, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 1, 10'h000, 1, 10'h3FF, 2, 10'h00A, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 1, 10'h000, 1, 10'h00A, 1, 10'h005, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 1, 10'h000, 1, 10'h005, 0, 10'h000, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 10'h123, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[10] = mk(1, 0, 1, 0, 10'h123, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 0, 10'h123, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[12] = mk(1, 0, 1, 0, 10'h123, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 1, 10'h000, 0, 10'h000, 0, 10'h000, 1, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 1, 10'h000, 1, 10'h000, 0, 10'h000, 1, 0, 0, 1);
    vecs[15] = mk(1, 1, 1, 0, 10'h040, 0, 10'h000, 1, 10'h040, 0, 0, 0, 1);
    vecs[16] = mk(1, 1, 1, 1, 10'h041, 1, 10'h040, 1, 10'h041, 0, 0, 0, 1);
    vecs[17] = mk(1, 1, 0, 0, 10'h155, 0, 10'h000, 1, 10'h041, 0, 0, 0, 1);
    vecs[18] = mk(1, 1, 1, 1, 10'h0AB, 1, 10'h041, 1, 10'h0AB, 0, 0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].pu, vecs[i].po, vecs[i].addr);
      if (vecs[i].chk_pre)
        chk($sformatf("v%0d_pre_top", i), 32'(top_out), 32'(vecs[i].pre_top));
      post($sformatf("v%0d", i), vecs[i].cnt, vecs[i].top,
           vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf);
    end

    // Replace on empty acts as a push.
    drive(0, 0, 0, 0, 10'h000);
    post("rst2", 0, 10'h000, 1, 0, 0, 0);
    drive(1, 1, 1, 1, 10'h0C3);
    post("repl_empty", 1, 10'h0C3, 0, 0, 0, 0);

    // Fill to full, then overflow and pop.
    drive(0, 0, 0, 0, 10'h000);
    post("rst3", 0, 10'h000, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 1, 0, 10'h010 + 10'(k));
      @(posedge clk);
      #1;
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_top", 32'(top_out), 32'h01F);
    drive(1, 1, 1, 0, 10'h2AA);
    post("ovf_push", 16, 10'h01F, 0, 1, 1, 0);
    drive(1, 1, 0, 1, 10'h000);
    chk("ovf_pop_pre_top", 32'(top_out), 32'h01F);
    post("ovf_pop", 15, 10'h01E, 0, 0, 1, 0);

    // Reset coinciding with a push drops the push and clears the sticky flag.
    drive(1, 1, 1, 0, 10'h061);
    post("pre_rst_push", 16, 10'h061, 0, 1, 1, 0);
    drive(0, 1, 1, 0, 10'h077);
    post("rst_push", 0, 10'h000, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 10'h001);
    post("after_rst", 1, 10'h001, 0, 0, 0, 0);

    // Short reset-mid-operation sequence from a partially filled stack.
    drive(1, 1, 1, 0, 10'h002);
    post("mid_p2", 2, 10'h002, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 10'h003);
    post("mid_p3", 3, 10'h003, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 10'h077);
    post("mid_rst", 0, 10'h000, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 10'h001);
    post("mid_push", 1, 10'h001, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 10'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
